// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART transmitter (and future RX):
//   - parity mode encodings as driven on parity_i
//   - transmitter FSM state encoding
//   - MIN_DIV, the smallest clocks-per-bit value the bit timer supports
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MIN_DIV = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word fall-through read data.
//   clk, resetn  : clock, synchronous active-low reset (clears pointers/level)
//   push_i       : write wdata_i; ignored while full
//   wdata_i      : write data
//   pop_i        : drop the head entry; ignored while empty
//   rdata_o      : head entry (valid while !empty_o)
//   full_o       : no free entries
//   empty_o      : no stored entries
//   level_o      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage carries no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// UART transmitter with runtime frame format and a FIFO-buffered input.
//   clk, resetn   : clock, synchronous active-low reset (aborts any frame,
//                   discards buffered words)
//   s_valid_i     : source offers s_data_i
//   s_ready_o     : FIFO not full; a word is taken on s_valid_i && s_ready_o
//   s_data_i      : character, sent LSB first
//   div_i         : clocks per bit, values below 2 act as 2
//   parity_i      : 00 none, 01 even, 10 odd, 11 none
//   stop2_i       : 0 one stop bit, 1 two stop bits
//   tx_o          : registered serial line, idles high
//   busy_o        : frame in progress or FIFO non-empty
//   fifo_level_o  : FIFO occupancy
// div_i/parity_i/stop2_i are sampled only when a word is popped, so changes
// mid-frame take effect from the next frame.
// -----------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [DATA_BITS-1:0]          s_data_i,
    input  logic [DIV_W-1:0]              div_i,
    input  logic [1:0]                    parity_i,
    input  logic                          stop2_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int BW = $clog2(DATA_BITS);

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (s_valid_i),
        .wdata_i (s_data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    tx_state_e            state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_en_q, par_en_d;
    logic                 stop2_q, stop2_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     baud_q, baud_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic                 stopcnt_q, stopcnt_d;

    logic [DIV_W-1:0]     div_eff;
    logic                 bit_end;

    assign div_eff   = (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;
    assign bit_end   = (baud_q == '0);
    assign s_ready_o = !fifo_full;
    assign busy_o    = (state_q != IDLE) || !fifo_empty;
    assign tx_o      = tx_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        div_d     = div_q;
        baud_d    = baud_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        fifo_pop  = 1'b0;

        // Bit timer: reload at every bit boundary, otherwise count down.
        if (state_q != IDLE) begin
            baud_d = bit_end ? (div_q - 1'b1) : (baud_q - 1'b1);
        end

        unique case (state_q)
            IDLE: begin
            end
            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bitcnt_q == BW'(DATA_BITS - 1)) begin
                        state_d   = par_en_q ? PARITY : STOP;
                        stopcnt_d = 1'b0;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    stopcnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stopcnt_q) begin
                        stopcnt_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame load: from IDLE, or straight out of the last stop bit so that
        // queued words go back-to-back. Overrides the defaults above.
        if (!fifo_empty && ((state_q == IDLE) ||
                            (state_q == STOP && bit_end && !(stop2_q && !stopcnt_q)))) begin
            fifo_pop  = 1'b1;
            state_d   = START;
            shreg_d   = fifo_rdata;
            par_en_d  = (parity_i == PAR_EVEN) || (parity_i == PAR_ODD);
            par_bit_d = (^fifo_rdata) ^ (parity_i == PAR_ODD);
            stop2_d   = stop2_i;
            div_d     = div_eff;
            baud_d    = div_eff - 1'b1;
            bitcnt_d  = '0;
        end
    end

    // Line level follows the current state one clock later, which keeps tx_o
    // on a flop while every bit still lasts exactly div clocks.
    always_comb begin
        unique case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_q[0];
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
        end
    end

    // Frame datapath: always reloaded on a pop before being used.
    always_ff @(posedge clk) begin
        shreg_q   <= shreg_d;
        par_bit_q <= par_bit_d;
        par_en_q  <= par_en_d;
        stop2_q   <= stop2_d;
        div_q     <= div_d;
        baud_q    <= baud_d;
        bitcnt_q  <= bitcnt_d;
        stopcnt_q <= stopcnt_d;
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

    localparam int DB = 8;
    localparam int FD = 4;
    localparam int DW = 16;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DB-1:0] s_data = '0;
    logic [DW-1:0] div = 16'd4;
    logic [1:0]    parity = 2'b00;
    logic          stop2 = 1'b0;
    logic          tx;
    logic          busy;
    logic [LW-1:0] level;

    uart_tx_cfg #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .DIV_W(DW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_data_i     (s_data),
        .div_i        (div),
        .parity_i     (parity),
        .stop2_i      (stop2),
        .tx_o         (tx),
        .busy_o       (busy),
        .fifo_level_o (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    // ---------------------------------------------------------------
    // Reference model: the FIFO is a queue of words; the line is a queue
    // of per-clock levels built from the frame definition when a word is
    // taken (start, LSB-first data, optional parity, 1 or 2 stops, each
    // repeated for the clamped divisor).
    // ---------------------------------------------------------------
    logic [DB-1:0] mq[$];
    bit            line[$];
    bit            m_tx = 1'b1;

    function automatic void build_frame(input logic [DB-1:0] w);
        bit b[$];
        int d;
        d = (div < 2) ? 2 : int'(div);
        b.push_back(1'b0);
        for (int i = 0; i < DB; i++) b.push_back(w[i]);
        if (parity == 2'b01) b.push_back(^w);
        else if (parity == 2'b10) b.push_back(~^w);
        b.push_back(1'b1);
        if (stop2) b.push_back(1'b1);
        foreach (b[k]) for (int r = 0; r < d; r++) line.push_back(b[k]);
    endfunction

    function automatic void model_step();
        int pre;
        if (!resetn) begin
            mq.delete();
            line.delete();
            m_tx = 1'b1;
        end else begin
            pre = mq.size();
            m_tx = (line.size() > 0) ? line.pop_front() : 1'b1;
            if (line.size() == 0 && pre > 0) build_frame(mq.pop_front());
            if (s_valid && pre < FD) mq.push_back(s_data);
        end
    endfunction

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx", int'(tx), int'(m_tx));
            chk("busy", int'(busy), int'(line.size() != 0 || mq.size() != 0));
            chk("level", int'(level), mq.size());
            chk("ready", int'(s_ready), int'(mq.size() < FD));
        end
    end

    // ---------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------
    bit trace[$];

    function automatic int tr(input int i);
        return (i >= 0 && i < trace.size()) ? int'(trace[i]) : -1;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    // Collect tx while busy, starting at the current negedge; returns count.
    task automatic collect(output int n);
        n = 0;
        trace.delete();
        while (busy && n < 3000) begin
            trace.push_back(tx);
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [DB-1:0] data;
        logic [DW-1:0] div;
        logic [1:0]    par;
        logic          st2;
        int            deff;
        int            len;
        int            pbit;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        int idx;
        int maxlvl;
        int zeros;
        int busy_seen;
        bit saw_full;
        bit rdy;
        logic [DB-1:0] words[6];

        tbl[0] = '{8'hA5, 16'd4, 2'b00, 1'b0, 4, 40, -1};
        tbl[1] = '{8'hA5, 16'd4, 2'b01, 1'b0, 4, 44, 0};
        tbl[2] = '{8'hA5, 16'd4, 2'b10, 1'b0, 4, 44, 1};
        tbl[3] = '{8'h00, 16'd3, 2'b00, 1'b1, 3, 33, -1};
        tbl[4] = '{8'h3C, 16'd0, 2'b00, 1'b0, 2, 20, -1};
        tbl[5] = '{8'h3C, 16'd1, 2'b10, 1'b1, 2, 24, 1};
        tbl[6] = '{8'h07, 16'd5, 2'b01, 1'b1, 5, 60, 1};

        // Reset
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ready", int'(s_ready), 1);
        resetn = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Single frames from a table
        for (int i = 0; i < 7; i++) begin
            wait_idle();
            div = tbl[i].div;
            parity = tbl[i].par;
            stop2 = tbl[i].st2;
            s_data = tbl[i].data;
            s_valid = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
            collect(n);
            // busy spans the one FIFO clock plus the frame itself
            chk("frame_len", n, tbl[i].len + 1);
            chk("pre_start_idle", tr(1), 1);
            chk("start_bit", tr(2), 0);
            chk("data_bit0", tr(2 + tbl[i].deff + tbl[i].deff / 2), int'(tbl[i].data[0]));
            if (tbl[i].pbit >= 0)
                chk("parity_bit", tr(2 + 9 * tbl[i].deff + tbl[i].deff / 2), tbl[i].pbit);
        end

        // Back-to-back 0x00, 0xFF with two stop bits at div 3
        wait_idle();
        div = 16'd3; parity = 2'b00; stop2 = 1'b1;
        s_valid = 1'b1; s_data = 8'h00;
        @(negedge clk);
        s_data = 8'hFF;
        @(negedge clk);
        s_valid = 1'b0;
        trace.delete();
        trace.push_back(1'b1);  // sample of the first accept edge, already past
        n = 1;
        while (busy && n < 3000) begin
            trace.push_back(tx);
            n++;
            @(negedge clk);
        end
        chk("b2b_len", n, 67);
        chk("b2b_last_data", tr(28), 0);
        chk("b2b_stop_first", tr(29), 1);
        chk("b2b_stop_last", tr(34), 1);
        chk("b2b_next_start", tr(35), 0);

        // FIFO fill with s_valid held high, six words at div 16
        wait_idle();
        div = 16'd16; parity = 2'b00; stop2 = 1'b0;
        for (int i = 0; i < 6; i++) words[i] = 8'(8'h11 * (i + 1));
        idx = 0; maxlvl = 0; saw_full = 1'b0;
        s_valid = 1'b1; s_data = words[0];
        for (int c = 0; c < 2000 && idx < 6; c++) begin
            rdy = s_ready;
            @(negedge clk);
            if (rdy) begin
                idx++;
                if (idx < 6) s_data = words[idx];
            end
            if (int'(level) > maxlvl) maxlvl = int'(level);
            if (level == LW'(FD) && !s_ready) saw_full = 1'b1;
        end
        s_valid = 1'b0;
        chk("fill_all_accepted", idx, 6);
        chk("fill_max_level", maxlvl, FD);
        chk("fill_ready_low_when_full", int'(saw_full), 1);
        wait_idle();

        // div changed mid-frame: 4 for the current frame, 8 for the next
        div = 16'd4; parity = 2'b00; stop2 = 1'b0;
        s_valid = 1'b1; s_data = 8'h5A;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (10) @(negedge clk);
        div = 16'd8;
        s_valid = 1'b1; s_data = 8'hC3;
        @(negedge clk);
        s_valid = 1'b0;
        wait_idle();

        // Reset during data bit 3 with two words queued
        div = 16'd4;
        s_valid = 1'b1; s_data = 8'h96;
        @(negedge clk);
        s_data = 8'h69;
        @(negedge clk);
        s_data = 8'hF0;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_rst_level", int'(level), 2);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_level", int'(level), 0);
        resetn = 1'b1;
        zeros = 0; busy_seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!tx) zeros++;
            if (busy) busy_seen++;
        end
        chk("post_rst_no_tx", zeros, 0);
        chk("post_rst_no_busy", busy_seen, 0);

        // Randomized traffic and configuration
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 3) == 0);
            s_data = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                div = 16'($urandom_range(0, 6));
                parity = 2'($urandom_range(0, 3));
                stop2 = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        wait_idle();
        chk("end_idle_tx", int'(tx), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
